// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: opcode map, ALU codes and FSM states.
package seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_LDB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_STB = 4'b0101;
  localparam logic [3:0] OP_LDC = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMACC,
    ST_HALT
  } state_t;

  // Loads and stores (0010..0101) go through the data-memory handshake.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op[3:1] == 3'b001) || (op[3:1] == 3'b010);
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_contador_timeout.sv
// Handshake wait counter: expire is high in the cycle whose missing ack would reach TIMEOUT.
module contador_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer: fetch/decode/execute/memory FSM driving a simple accumulator datapath.
module sequenciador_multiciclo
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W+3:0] imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_ack,
  input  logic              a_zero,
  output logic [3:0]        ir_opcode,
  output logic [ADDR_W-1:0] ir_imm,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        alu_op,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              a_we,
  output logic              b_we,
  output logic              store_sel_b,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              timeout_err
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_d, imm_d;
  logic [3:0]        op_d;
  logic              illegal_d, terr_d;
  logic              waiting, acked, expire;

  // Only acks belonging to the current handshake count; stray ones are ignored.
  assign waiting = (state == ST_FETCH) || (state == ST_MEMACC);
  assign acked   = ((state == ST_FETCH) && imem_ack) || ((state == ST_MEMACC) && dmem_ack);

  contador_timeout #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!waiting || acked),
    .enable (waiting && !acked),
    .expire (expire)
  );

  assign imem_addr = pc;
  assign dmem_addr = ir_imm;
  assign halted    = (state == ST_HALT);
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir_opcode   <= '0;
      ir_imm      <= '0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      ir_opcode   <= op_d;
      ir_imm      <= imm_d;
      illegal     <= illegal_d;
      timeout_err <= terr_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    op_d        = ir_opcode;
    imm_d       = ir_imm;
    illegal_d   = illegal;
    terr_d      = timeout_err;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    store_sel_b = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    alu_op      = ALU_ADD;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          op_d    = imem_rdata[ADDR_W +: 4];
          imm_d   = imem_rdata[ADDR_W-1:0];
          state_d = ST_DECODE;
        end else if (expire) begin
          terr_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (ir_opcode[3]) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (is_mem_op(ir_opcode)) begin
          state_d = ST_MEMACC;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc + ADDR_W'(1);
        case (ir_opcode)
          OP_ADD: begin a_we = 1'b1; alu_src = 1'b1; alu_op = ALU_ADD;  end
          OP_SUB: begin a_we = 1'b1; alu_src = 1'b1; alu_op = ALU_SUB;  end
          OP_LDC: begin a_we = 1'b1; alu_src = 1'b1; alu_op = ALU_PASS; end
          OP_JMP: if (a_zero) pc_d = ir_imm;
          default: ;
        endcase
      end
      ST_MEMACC: begin
        dmem_req    = 1'b1;
        dmem_we     = (ir_opcode == OP_STA) || (ir_opcode == OP_STB);
        store_sel_b = (ir_opcode == OP_STB);
        // Load write-enables fire on the ack edge, when the datapath sees the read data.
        if (dmem_ack) begin
          a_we       = (ir_opcode == OP_LDA);
          b_we       = (ir_opcode == OP_LDB);
          mem_to_reg = (ir_opcode == OP_LDA) || (ir_opcode == OP_LDB);
          pc_d       = pc + ADDR_W'(1);
          state_d    = ST_FETCH;
        end else if (expire) begin
          terr_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (start) begin
          illegal_d = 1'b0;
          terr_d    = 1'b0;
          pc_d      = '0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/sequenciador_multiciclo.md
SEQUENCIADOR_MULTICICLO -- requirements
Module: sequenciador_multiciclo

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the PC, immediate and data-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum number of wait cycles for a memory acknowledge.
REQ-003 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_n (in, 1, synchronous active-low reset); one clock, reset synchronous and active-low.
REQ-004 SHALL have start (in, 1, run request), imem_req (out, 1, fetch request), imem_addr (out, ADDR_W, equals pc), imem_rdata (in, 4+ADDR_W, instruction word) and imem_ack (in, 1, fetch done).
REQ-005 SHALL have dmem_req (out, 1), dmem_we (out, 1, store), dmem_addr (out, ADDR_W, equals ir_imm) and dmem_ack (in, 1, data access done).
REQ-006 SHALL have a_zero (in, 1, datapath A==0), ir_opcode (out, 4) and ir_imm (out, ADDR_W).
REQ-007 SHALL have pc (out, ADDR_W), alu_op (out, 2: 00 add, 01 sub, 10 pass immediate), alu_src (out, 1) and mem_to_reg (out, 1).
REQ-008 SHALL have a_we (out, 1), b_we (out, 1), store_sel_b (out, 1, store data from B) and busy (out, 1).
REQ-009 SHALL have halted (out, 1), illegal (out, 1, sticky) and timeout_err (out, 1, sticky).

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, MEMACC and HALT.
REQ-011 IDLE: start=1 -> FETCH next cycle; busy=0 in IDLE and HALT, busy=1 in all other states.
REQ-012 FETCH: imem_req=1 with imem_addr=pc held stable until imem_ack; ack accepted in the same cycle req rises; on ack IR<=imem_rdata (opcode = bits [ADDR_W+3:ADDR_W], imm = low ADDR_W bits) and state -> DECODE.
REQ-013 DECODE: one cycle; opcodes 0000/0001/0110/0111 -> EXEC; 0010/0011/0100/0101 -> MEMACC; opcodes 1000-1111 -> HALT with illegal<=1 and pc unchanged.
REQ-014 EXEC: one cycle with alu_src=1 and a_we pulsed for ADD (alu_op=00), SUB (01) and LDC (10); for JMP, no write enable, pc<=ir_imm if a_zero=1, else pc+1; all other instructions pc<=pc+1; next state FETCH.
REQ-015 MEMACC: dmem_req=1 and dmem_addr=ir_imm held until dmem_ack; dmem_we=1 for STA/STB; store_sel_b=1 for STB only.
REQ-016 MEMACC load completion: in the dmem_ack cycle, LDA pulses a_we and LDB pulses b_we, both with mem_to_reg=1 (datapath samples dmem data that edge).
REQ-017 MEMACC exit: on dmem_ack, pc<=pc+1 and state -> FETCH.
REQ-018 a_we and b_we SHALL be single-cycle pulses, never both high; dmem_we SHALL only be high while dmem_req is high.
REQ-019 pc increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-020 Wait counter: cleared on entry to FETCH/MEMACC and incremented each cycle without ack; on reaching TIMEOUT with no ack, drop req the next cycle, set timeout_err<=1 and go to HALT.
REQ-021 An ack arriving on the same cycle the wait counter reaches TIMEOUT SHALL win (normal completion, no error).
REQ-022 HALT: halted=1 and all strobes 0; start=1 clears illegal/timeout_err, sets pc<=0 and goes to FETCH.
REQ-023 start SHALL be ignored while busy=1; imem_ack outside FETCH and dmem_ack outside MEMACC SHALL be ignored.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, pc=0, IR=0, wait counter 0, and all outputs 0 (busy, halted, illegal, timeout_err, all req/we/select strobes).
REQ-025 Reset SHALL take priority in any state, including mid-handshake, dropping req the following cycle.

Structure
REQ-026 The shared package seq_pkg SHALL hold the opcode constants, the FSM state enum and the alu_op codes.
REQ-027 The wait counter SHALL be the sub-module contador_timeout (clear, enable, expire output).

Verification
REQ-028 Reset, start, ADD #5 at pc 0 with immediate imem_ack -> FETCH/DECODE/EXEC in 3 cycles, a_we pulse with alu_op=00 and alu_src=1, pc=1.
REQ-029 JMP #0x20 with a_zero=1 -> pc=0x20; same instruction with a_zero=0 -> pc=1.
REQ-030 LDB #0x10 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_addr=0x10, b_we and mem_to_reg pulse in the ack cycle only.
REQ-031 Opcode 1010 fetched -> HALT, illegal=1, busy=0; then start -> pc=0, illegal=0, FETCH.
REQ-032 imem_ack withheld -> timeout_err=1 after TIMEOUT=16 wait cycles, HALT; separately, ack on the 16th cycle -> no error.
REQ-033 Instruction at pc 0xFF (not JMP) completes -> pc=0x00; rst_n=0 during MEMACC -> all outputs 0 next cycle.
